// File: rtl/adder_link_pkg.sv
// adder_link_pkg
// Shared definitions for the adder link host: TX/RX state encodings,
// a constant-evaluable clog2 helper and the counter width for the
// default 16-bit word.
package adder_link_pkg;

  // Ceiling log2 for sizing bit counters (value >= 2 in practice).
  function automatic int clog2(input int value);
    int v_rem;
    int v_res;
    v_rem = value - 1;
    v_res = 0;
    while (v_rem > 0) begin
      v_res = v_res + 1;
      v_rem = v_rem >> 1;
    end
    return v_res;
  endfunction

  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_W          = clog2(DATA_WIDTH_DEF);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_t;

endpackage

// File: rtl/adder_link_rx.sv
// adder_link_rx
// Receive half of the adder link host: gathers the serial sum stream
// (LSB first) into a parallel word and holds it until the consumer
// takes it.
// Ports:
//   i_clk, i_rst, i_en      clock, sync active-high reset, global enable
//   i_sum, i_sum_valid      serial sum bit and its valid
//   o_sum_ready             high while collecting bits
//   ov_result               assembled word (stable while o_result_valid)
//   o_result_valid          a complete word is held
//   i_result_ready          consumer takes the word
module adder_link_rx
  import adder_link_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_sum,
  input  logic                  i_sum_valid,
  output logic                  o_sum_ready,
  output logic [DATA_WIDTH-1:0] ov_result,
  output logic                  o_result_valid,
  input  logic                  i_result_ready
);

  localparam int                 L_CNT_W = clog2(DATA_WIDTH);
  localparam logic [L_CNT_W-1:0] L_LAST  = L_CNT_W'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [L_CNT_W-1:0]    r_cnt;
  logic                  w_sum_fire;
  logic                  w_res_fire;

  // Qualify the two RX handshakes with enable and the current state.
  always_comb begin
    w_sum_fire = 1'b0;
    w_res_fire = 1'b0;
    if (i_en) begin
      w_sum_fire = i_sum_valid & (r_state == RX_COLLECT);
      w_res_fire = i_result_ready & (r_state == RX_HOLD);
    end else begin
      w_sum_fire = 1'b0;
      w_res_fire = 1'b0;
    end
  end

  // RX state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RX_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RX next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_COLLECT: begin
        if (w_sum_fire && (r_cnt == L_LAST)) begin
          w_state_nxt = RX_HOLD;
        end else begin
          w_state_nxt = RX_COLLECT;
        end
      end
      RX_HOLD: begin
        if (w_res_fire) begin
          w_state_nxt = RX_COLLECT;
        end else begin
          w_state_nxt = RX_HOLD;
        end
      end
      default: w_state_nxt = RX_COLLECT;
    endcase
  end

  // Shift register and bit counter. The counter is cleared when the word
  // is handed off so non-power-of-two widths restart cleanly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= {DATA_WIDTH{1'b0}};
      r_cnt   <= {L_CNT_W{1'b0}};
    end else if (w_sum_fire) begin
      r_shift <= {i_sum, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= r_cnt + L_CNT_W'(1);
    end else if (w_res_fire) begin
      r_cnt   <= {L_CNT_W{1'b0}};
    end
  end

  assign o_sum_ready    = (r_state == RX_COLLECT);
  assign o_result_valid = (r_state == RX_HOLD);
  assign ov_result      = r_shift;

endmodule

// File: rtl/adder_link_host.sv
// adder_link_host
// Host-side peer of the bit-serial adder. Serializes parallel operand
// pairs onto two lock-stepped lanes (A, B), LSB first, and reassembles
// the returning serial sum into parallel words (via adder_link_rx).
// Ports:
//   i_clk, i_rst, i_en           clock, sync active-high reset, global enable
//   iv_a, iv_b, i_op_valid       operand pair and its valid
//   o_op_ready                   TX idle, pair can be accepted
//   o_din_a, o_din_b, o_valid    serial lanes to the adder and their valid
//   i_ready                      adder accepts a serial bit
//   i_sum, i_sum_valid           serial sum from the adder
//   o_sum_ready                  host accepts a sum bit
//   ov_result, o_result_valid    reassembled sum word and its valid
//   i_result_ready               consumer takes the word
// All outputs come from registers or from decoding registered state.
module adder_link_host
  import adder_link_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] iv_a,
  input  logic [DATA_WIDTH-1:0] iv_b,
  input  logic                  i_op_valid,
  output logic                  o_op_ready,
  output logic                  o_din_a,
  output logic                  o_din_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic                  i_sum,
  input  logic                  i_sum_valid,
  output logic                  o_sum_ready,
  output logic [DATA_WIDTH-1:0] ov_result,
  output logic                  o_result_valid,
  input  logic                  i_result_ready
);

  localparam int                 L_CNT_W = clog2(DATA_WIDTH);
  localparam logic [L_CNT_W-1:0] L_LAST  = L_CNT_W'(DATA_WIDTH - 1);

  tx_state_t             r_tx_state;
  tx_state_t             w_tx_state_nxt;
  logic [DATA_WIDTH-1:0] r_sh_a;
  logic [DATA_WIDTH-1:0] r_sh_b;
  logic [L_CNT_W-1:0]    r_tx_cnt;
  logic                  w_op_fire;
  logic                  w_bit_fire;

  // Qualify the operand and serial-bit handshakes with enable and state.
  always_comb begin
    w_op_fire  = 1'b0;
    w_bit_fire = 1'b0;
    if (i_en) begin
      w_op_fire  = i_op_valid & (r_tx_state == TX_IDLE);
      w_bit_fire = i_ready & (r_tx_state == TX_SEND);
    end else begin
      w_op_fire  = 1'b0;
      w_bit_fire = 1'b0;
    end
  end

  // TX state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nxt;
    end
  end

  // TX next-state decode.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_op_fire) begin
          w_tx_state_nxt = TX_SEND;
        end else begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      TX_SEND: begin
        if (w_bit_fire && (r_tx_cnt == L_LAST)) begin
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_state_nxt = TX_SEND;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // Operand shift registers and bit counter. Zero fill means the lanes
  // return to 0 once a whole word has been shifted out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_a   <= {DATA_WIDTH{1'b0}};
      r_sh_b   <= {DATA_WIDTH{1'b0}};
      r_tx_cnt <= {L_CNT_W{1'b0}};
    end else if (w_op_fire) begin
      r_sh_a   <= iv_a;
      r_sh_b   <= iv_b;
      r_tx_cnt <= {L_CNT_W{1'b0}};
    end else if (w_bit_fire) begin
      r_sh_a   <= {1'b0, r_sh_a[DATA_WIDTH-1:1]};
      r_sh_b   <= {1'b0, r_sh_b[DATA_WIDTH-1:1]};
      r_tx_cnt <= r_tx_cnt + L_CNT_W'(1);
    end
  end

  assign o_op_ready = (r_tx_state == TX_IDLE);
  assign o_valid    = (r_tx_state == TX_SEND);
  assign o_din_a    = r_sh_a[0];
  assign o_din_b    = r_sh_b[0];

  adder_link_rx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .i_sum          (i_sum),
    .i_sum_valid    (i_sum_valid),
    .o_sum_ready    (o_sum_ready),
    .ov_result      (ov_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready)
  );

endmodule

// File: tb/tb_adder_link_host.sv
// Self-checking bench for adder_link_host. The bench plays the adder:
// it captures the serial operand lanes, adds them with plain arithmetic
// and streams the sum back into the RX side.
module tb_adder_link_host;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic        op_valid;
  logic        op_ready;
  logic        din_a;
  logic        din_b;
  logic        valid;
  logic        ready;
  logic        sum;
  logic        sum_valid;
  logic        sum_ready;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;

  int n_pass  = 0;
  int n_total = 0;

  adder_link_host #(.DATA_WIDTH(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .iv_a           (a),
    .iv_b           (b),
    .i_op_valid     (op_valid),
    .o_op_ready     (op_ready),
    .o_din_a        (din_a),
    .o_din_b        (din_b),
    .o_valid        (valid),
    .i_ready        (ready),
    .i_sum          (sum),
    .i_sum_valid    (sum_valid),
    .o_sum_ready    (sum_ready),
    .ov_result      (result),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; a = 16'h0; b = 16'h0; op_valid = 1'b0;
    ready = 1'b0; sum = 1'b0; sum_valid = 1'b0; result_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Offer an operand pair and wait (bounded) until it is accepted.
  task automatic offer_op(input logic [15:0] wa, input logic [15:0] wb);
    int t;
    t = 0;
    a = wa; b = wb; op_valid = 1'b1;
    while (!op_ready && t < 200) begin tick(); t++; end
    if (t >= 200) begin
      n_total++;
      $display("FAIL op_accept_timeout: op_ready=%0b required 1", op_ready);
    end
    tick();
    op_valid = 1'b0;
  endtask

  // Adder side of TX: sample the lanes on every transfer (random or
  // constant ready) and rebuild the operand words.
  task automatic tx_word(input logic [15:0] wa, input logic [15:0] wb, input bit rnd,
                         output logic [15:0] ga, output logic [15:0] gb);
    int n;
    int c;
    offer_op(wa, wb);
    n = 0; c = 0; ga = 16'h0; gb = 16'h0;
    while (n < 16 && c < 400) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid && ready) begin ga[n] = din_a; gb[n] = din_b; n++; end
      tick(); c++;
    end
    ready = 1'b0;
    if (n < 16) begin
      n_total++;
      $display("FAIL tx_timeout: bits=%0d required 16", n);
    end
  endtask

  // Adder side of RX: stream bits [first..15] of w, LSB first.
  task automatic rx_word(input logic [15:0] w, input int first, input bit gaps);
    int t;
    for (int i = first; i < 16; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin sum_valid = 1'b0; tick(); end
      sum = w[i]; sum_valid = 1'b1; t = 0;
      while (!sum_ready && t < 200) begin tick(); t++; end
      if (t >= 200) begin
        n_total++;
        $display("FAIL rx_timeout: sum_ready=%0b required 1", sum_ready);
      end
      tick();
    end
    sum_valid = 1'b0;
  endtask

  // Consumer: wait for a word, optionally delay, then take it.
  task automatic get_result(input int delay, output logic [15:0] r);
    int t;
    t = 0;
    while (!result_valid && t < 200) begin tick(); t++; end
    if (t >= 200) begin
      n_total++;
      $display("FAIL result_timeout: result_valid=%0b required 1", result_valid);
    end
    repeat (delay) tick();
    r = result;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({op_ready, sum_ready, valid, din_a, din_b, result_valid, result} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset: got rdy=%0b srdy=%0b v=%0b da=%0b db=%0b rv=%0b res=%h required 1 1 0 0 0 0 0000",
               op_ready, sum_ready, valid, din_a, din_b, result_valid, result);
    else n_pass++;
  endtask

  // Closed loop: fixed pairs from the plan, then random pairs.
  task automatic test_closed_loop();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [15:0] ga, gb, r, e_sum;
    va[0] = 16'h0001; vb[0] = 16'h0002;
    va[1] = 16'h7FFF; vb[1] = 16'h0001;
    for (int i = 2; i < 6; i++) begin va[i] = 16'($urandom); vb[i] = 16'($urandom); end
    for (int i = 0; i < 6; i++) begin
      e_sum = va[i] + vb[i];
      tx_word(va[i], vb[i], 1'b0, ga, gb);
      n_total++;
      if ({ga, gb} !== {va[i], vb[i]})
        $display("FAIL loop_lanes[%0d]: got a=%h b=%h required a=%h b=%h", i, ga, gb, va[i], vb[i]);
      else n_pass++;
      rx_word(ga + gb, 0, 1'b0);
      get_result(0, r);
      n_total++;
      if (r !== e_sum) $display("FAIL loop_result[%0d]: got %h required %h", i, r, e_sum);
      else n_pass++;
    end
  endtask

  // Random ready on TX, gappy sum stream, random consumer delay.
  task automatic test_random_traffic();
    logic [15:0] wa, wb, ga, gb, r, e_sum;
    for (int i = 0; i < 6; i++) begin
      wa = 16'($urandom); wb = 16'($urandom); e_sum = wa + wb;
      tx_word(wa, wb, 1'b1, ga, gb);
      rx_word(ga + gb, 0, 1'b1);
      get_result(int'($urandom_range(0, 3)), r);
      n_total++;
      if (r !== e_sum) $display("FAIL random_result[%0d]: got %h required %h", i, r, e_sum);
      else n_pass++;
    end
  endtask

  task automatic test_tx_bit_order();
    logic [15:0] e_a;
    e_a = 16'h8001;
    offer_op(e_a, 16'h0000);
    ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      n_total++;
      if ({valid, op_ready, din_a, din_b} !== {1'b1, 1'b0, e_a[n], 1'b0})
        $display("FAIL bit_order[%0d]: got v=%0b rdy=%0b a=%0b b=%0b required 1 0 %0b 0",
                 n, valid, op_ready, din_a, din_b, e_a[n]);
      else n_pass++;
      tick();
    end
    ready = 1'b0;
    n_total++;
    if ({op_ready, valid} !== 2'b10)
      $display("FAIL bit_order_end: got rdy=%0b v=%0b required 1 0", op_ready, valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] wa, wb;
    logic [1:0]  prev;
    int n, c;
    bit stalled;
    wa = 16'($urandom); wb = 16'($urandom);
    offer_op(wa, wb);
    n = 0; c = 0;
    while (n < 16 && c < 100) begin
      ready = (c % 2 == 0);
      stalled = !ready;
      prev = {din_a, din_b};
      if (ready) begin
        n_total++;
        if ({valid, din_a, din_b} !== {1'b1, wa[n], wb[n]})
          $display("FAIL bp_bit[%0d]: got v=%0b a=%0b b=%0b required 1 %0b %0b",
                   n, valid, din_a, din_b, wa[n], wb[n]);
        else n_pass++;
        n++;
      end
      tick(); c++;
      if (stalled) begin
        n_total++;
        if ({valid, din_a, din_b} !== {1'b1, prev})
          $display("FAIL bp_stall_hold[%0d]: got v=%0b a=%0b b=%0b required 1 %0b %0b",
                   c, valid, din_a, din_b, prev[1], prev[0]);
        else n_pass++;
      end
    end
    ready = 1'b0;
    n_total++;
    if (c !== 31 || op_ready !== 1'b1)
      $display("FAIL bp_cycles: got cycles=%0d rdy=%0b required 31 1", c, op_ready);
    else n_pass++;
  endtask

  task automatic test_rx_hold();
    logic [15:0] w2, r;
    w2 = 16'($urandom) | 16'h0001;
    rx_word(16'hA5A5, 0, 1'b0);
    sum = 1'b1; sum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({result_valid, sum_ready, result} !== {1'b1, 1'b0, 16'hA5A5})
        $display("FAIL rx_hold[%0d]: got rv=%0b srdy=%0b res=%h required 1 0 a5a5",
                 i, result_valid, sum_ready, result);
      else n_pass++;
      tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    n_total++;
    if ({result_valid, sum_ready} !== 2'b01)
      $display("FAIL rx_release: got rv=%0b srdy=%0b required 0 1", result_valid, sum_ready);
    else n_pass++;
    tick();
    rx_word(w2, 1, 1'b0);
    get_result(0, r);
    n_total++;
    if (r !== w2) $display("FAIL rx_after_hold: got %h required %h", r, w2);
    else n_pass++;
  endtask

  task automatic test_enable_freeze();
    logic [15:0] wa, wb, ga, gb, r, e_sum;
    logic [2:0]  prev;
    int n, c;
    bit frz;
    wa = 16'($urandom); wb = 16'($urandom);
    wa[8:5] = 4'b0101; e_sum = wa + wb;
    offer_op(wa, wb);
    ready = 1'b1; n = 0; c = 0; frz = 1'b0; ga = 16'h0; gb = 16'h0;
    while (n < 16 && c < 100) begin
      if (n == 5 && !frz) begin
        en = 1'b0;
        prev = {valid, din_a, din_b};
        repeat (3) begin
          tick(); c++;
          n_total++;
          if ({valid, din_a, din_b} !== prev)
            $display("FAIL freeze_hold[%0d]: got %b required %b", c, {valid, din_a, din_b}, prev);
          else n_pass++;
        end
        en = 1'b1; frz = 1'b1;
      end
      if (valid) begin ga[n] = din_a; gb[n] = din_b; n++; end
      tick(); c++;
    end
    ready = 1'b0;
    n_total++;
    if (c !== 19 || op_ready !== 1'b1 || {ga, gb} !== {wa, wb})
      $display("FAIL freeze_word: got cycles=%0d rdy=%0b a=%h b=%h required 19 1 %h %h",
               c, op_ready, ga, gb, wa, wb);
    else n_pass++;
    rx_word(ga + gb, 0, 1'b0);
    get_result(0, r);
    n_total++;
    if (r !== e_sum) $display("FAIL freeze_result: got %h required %h", r, e_sum);
    else n_pass++;
  endtask

  task automatic test_mid_word_reset();
    logic [15:0] ga, gb, r;
    offer_op(16'($urandom), 16'($urandom));
    ready = 1'b1; sum_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sum = 1'($urandom_range(0, 1));
      tick();
    end
    n_total++;
    if ({valid, sum_ready} !== 2'b11)
      $display("FAIL midrst_pre: got v=%0b srdy=%0b required 1 1", valid, sum_ready);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0; sum_valid = 1'b0;
    n_total++;
    if ({valid, op_ready, sum_ready, result_valid, din_a, din_b, result} !==
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL midrst_state: got v=%0b rdy=%0b srdy=%0b rv=%0b da=%0b db=%0b res=%h required 0 1 1 0 0 0 0000",
               valid, op_ready, sum_ready, result_valid, din_a, din_b, result);
    else n_pass++;
    tx_word(16'h1234, 16'h0001, 1'b0, ga, gb);
    rx_word(ga + gb, 0, 1'b0);
    get_result(0, r);
    n_total++;
    if (r !== 16'h1235) $display("FAIL midrst_word: got %h required 1235", r);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_closed_loop();
    test_tx_bit_order();
    test_backpressure();
    test_rx_hold();
    test_enable_freeze();
    test_random_traffic();
    test_mid_word_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
